// File: rtl/mat_sched.sv
// Matrix-multiply sequencer for picoMIPS: steps the register file and ALU through
// C = A x B using multiply and accumulate ops while holding the CPU.
`timescale 1ns/1ps
module mat_sched #(
    parameter int         n        = 8,
    parameter int         NDIM     = 2,
    parameter int         A_BASE   = 1,
    parameter int         B_BASE   = 5,
    parameter int         C_BASE   = 9,
    parameter int         T_REG    = 13,
    parameter logic [2:0] FUNC_ADD = 3'b001,
    parameter logic [2:0] FUNC_MUL = 3'b110,
    parameter int         OVF_BIT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [n/2-1:0]   flags,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic [4:0]       raddr1,
    output logic [4:0]       raddr2,
    output logic [4:0]       waddr,
    output logic [2:0]       alu_func,
    output logic             imm,
    output logic             w,
    output logic             ovf
);

    typedef enum logic [2:0] {IDLE, MUL0, MULT, ACC, FIN} state_e;

    localparam logic [1:0] LAST = 2'(NDIM - 1);

    state_e     state_q, state_d;
    logic [1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic       busy_q, done_q, w_q, imm_q, ovf_q;
    logic       busy_d, done_d, w_d, ovf_d;
    logic [4:0] raddr1_q, raddr2_q, waddr_q;
    logic [4:0] raddr1_d, raddr2_d, waddr_d;
    logic [2:0] alu_func_q, alu_func_d;

    // Only the overflow flag matters here; the rest of the flag bus is ignored.
    logic unused_flags;
    assign unused_flags = ^flags;

    function automatic logic [4:0] rc_addr(input int base, input logic [1:0] r, input logic [1:0] c);
        return 5'(base + NDIM * int'(r) + int'(c));
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = MUL0;
                i_d     = 2'd0;
                j_d     = 2'd0;
                k_d     = 2'd0;
            end
            MUL0: begin
                state_d = MULT;
                k_d     = 2'd1;
            end
            MULT: state_d = ACC;
            ACC: begin
                if (k_q != LAST) begin
                    k_d     = k_q + 2'd1;
                    state_d = MULT;
                end else if (i_q == LAST && j_q == LAST) begin
                    state_d = FIN;
                end else begin
                    k_d     = 2'd0;
                    state_d = MUL0;
                    if (j_q == LAST) begin
                        j_d = 2'd0;
                        i_d = i_q + 2'd1;
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the op appears in the same cycle as its state.
    always_comb begin
        raddr1_d   = 5'd0;
        raddr2_d   = 5'd0;
        waddr_d    = 5'd0;
        alu_func_d = 3'd0;
        w_d        = 1'b0;
        busy_d     = 1'b0;
        done_d     = (state_d == FIN);
        case (state_d)
            MUL0, MULT: begin
                raddr1_d   = rc_addr(A_BASE, i_d, k_d);
                raddr2_d   = rc_addr(B_BASE, k_d, j_d);
                waddr_d    = (state_d == MUL0) ? rc_addr(C_BASE, i_d, j_d) : 5'(T_REG);
                alu_func_d = FUNC_MUL;
                w_d        = 1'b1;
                busy_d     = 1'b1;
            end
            ACC: begin
                raddr1_d   = rc_addr(C_BASE, i_d, j_d);
                raddr2_d   = 5'(T_REG);
                waddr_d    = rc_addr(C_BASE, i_d, j_d);
                alu_func_d = FUNC_ADD;
                w_d        = 1'b1;
                busy_d     = 1'b1;
            end
            default: ;
        endcase
        // An accepted start clears the sticky overflow; otherwise any flagged write sets it.
        if (state_q == IDLE && start) ovf_d = 1'b0;
        else                          ovf_d = ovf_q | (w_q & flags[OVF_BIT]);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            i_q        <= 2'd0;
            j_q        <= 2'd0;
            k_q        <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= 1'b0;
            imm_q      <= 1'b0;
            ovf_q      <= 1'b0;
            raddr1_q   <= 5'd0;
            raddr2_q   <= 5'd0;
            waddr_q    <= 5'd0;
            alu_func_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            w_q        <= w_d;
            imm_q      <= 1'b0;
            ovf_q      <= ovf_d;
            raddr1_q   <= raddr1_d;
            raddr2_q   <= raddr2_d;
            waddr_q    <= waddr_d;
            alu_func_q <= alu_func_d;
        end
    end

    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;
    assign raddr1   = raddr1_q;
    assign raddr2   = raddr2_q;
    assign waddr    = waddr_q;
    assign alu_func = alu_func_q;
    assign imm      = imm_q;
    assign w        = w_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_mat_sched.sv
// Bench for mat_sched: register-file/ALU model around a 2x2 and a 3x3 instance,
// with an op-trace and result scoreboard.
`timescale 1ns/1ps
module tb_mat_sched;

    typedef struct packed {
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] wa;
        logic [2:0] fn;
    } op_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] val;
    } res_t;

    localparam logic [2:0] F_ADD = 3'b001;
    localparam logic [2:0] F_MUL = 3'b110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, start2 = 1'b0, start3 = 1'b0, sel3 = 1'b0;
    logic ld2 = 1'b0, ld3 = 1'b0;
    logic [7:0] init_v [32];
    logic [7:0] rf2 [32];
    logic [7:0] rf3 [32];

    logic [3:0] flags2, flags3;
    logic [7:0] res2, res3;
    logic       busy2, hold2, done2, imm2, w2, ovf2;
    logic       busy3, hold3, done3, imm3, w3, ovf3;
    logic [4:0] ra1_2, ra2_2, wa_2, ra1_3, ra2_3, wa_3;
    logic [2:0] fn2, fn3;

    mat_sched #(.n(8), .NDIM(2), .A_BASE(1), .B_BASE(5), .C_BASE(9), .T_REG(13),
                .FUNC_ADD(F_ADD), .FUNC_MUL(F_MUL), .OVF_BIT(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .flags(flags2),
        .busy(busy2), .cpu_hold(hold2), .done(done2), .raddr1(ra1_2), .raddr2(ra2_2),
        .waddr(wa_2), .alu_func(fn2), .imm(imm2), .w(w2), .ovf(ovf2));

    mat_sched #(.n(8), .NDIM(3), .A_BASE(1), .B_BASE(10), .C_BASE(19), .T_REG(28),
                .FUNC_ADD(F_ADD), .FUNC_MUL(F_MUL), .OVF_BIT(1)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .flags(flags3),
        .busy(busy3), .cpu_hold(hold3), .done(done3), .raddr1(ra1_3), .raddr2(ra2_3),
        .waddr(wa_3), .alu_func(fn3), .imm(imm3), .w(w3), .ovf(ovf3));

    // ALU model: flags = {2'b00, signed overflow, zero}, result in the low byte.
    function automatic logic [11:0] alu(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic v;
        logic signed [15:0] p;
        r = 8'd0;
        v = 1'b0;
        if (fn == F_ADD) begin
            r = a + b;
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end else if (fn == F_MUL) begin
            p = $signed(a) * $signed(b);
            r = p[7:0];
            v = (p != {{8{r[7]}}, r});
        end
        return {2'b00, v, (r == 8'd0), r};
    endfunction

    assign {flags2, res2} = alu(fn2, rf2[ra1_2], rf2[ra2_2]);
    assign {flags3, res3} = alu(fn3, rf3[ra1_3], rf3[ra2_3]);

    always @(posedge clk) begin
        if (ld2) for (int r = 0; r < 32; r++) rf2[r] <= init_v[r];
        else if (w2) rf2[wa_2] <= res2;
        if (ld3) for (int r = 0; r < 32; r++) rf3[r] <= init_v[r];
        else if (w3) rf3[wa_3] <= res3;
    end

    wire       o_busy = sel3 ? busy3 : busy2;
    wire       o_hold = sel3 ? hold3 : hold2;
    wire       o_done = sel3 ? done3 : done2;
    wire       o_w    = sel3 ? w3    : w2;
    wire       o_imm  = sel3 ? imm3  : imm2;
    wire       o_ovf  = sel3 ? ovf3  : ovf2;
    wire op_t  o_op   = sel3 ? {ra1_3, ra2_3, wa_3, fn3} : {ra1_2, ra2_2, wa_2, fn2};

    op_t  op_q [$];
    res_t res_q [$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic v);
        if (sel3) start3 = v;
        else      start2 = v;
    endtask

    // Loads A and B (row-major value lists) into the selected register file.
    task automatic load_mats(input int nd, input int ab, input int bb, input int a [9], input int b [9]);
        for (int r = 0; r < 32; r++) init_v[r] = 8'd0;
        for (int e = 0; e < nd * nd; e++) begin
            init_v[ab + e] = 8'(a[e]);
            init_v[bb + e] = 8'(b[e]);
        end
        if (sel3) ld3 = 1'b1;
        else      ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        ld3 = 1'b0;
    endtask

    // Expected op trace and final C from a plain triple loop over init_v.
    task automatic push_expected(input int nd, input int ab, input int bb, input int cb, input int tr);
        logic [7:0] acc;
        for (int i = 0; i < nd; i++) begin
            for (int j = 0; j < nd; j++) begin
                op_q.push_back(op_t'{5'(ab + i*nd), 5'(bb + j), 5'(cb + i*nd + j), F_MUL});
                acc = init_v[ab + i*nd] * init_v[bb + j];
                for (int k = 1; k < nd; k++) begin
                    op_q.push_back(op_t'{5'(ab + i*nd + k), 5'(bb + k*nd + j), 5'(tr), F_MUL});
                    op_q.push_back(op_t'{5'(cb + i*nd + j), 5'(tr), 5'(cb + i*nd + j), F_ADD});
                    acc = acc + init_v[ab + i*nd + k] * init_v[bb + k*nd + j];
                end
                res_q.push_back(res_t'{5'(cb + i*nd + j), acc});
            end
        end
    endtask

    task automatic run(input int nd, input int poke, input logic exp_ovf, input logic keep);
        int ops;
        op_t e;
        res_t er;
        logic [7:0] got;
        ops = nd * nd * (2 * nd - 1);
        drive_start(1'b1);
        tick();
        for (int c = 1; c <= ops; c++) begin
            drive_start(keep || c == poke);
            total_cnt++;
            if ({o_busy, o_hold, o_w, o_done, o_imm} !== 5'b11100)
                $display("FAIL busy_window cycle %0d: busy/hold/w/done/imm=%b want 11100", c,
                         {o_busy, o_hold, o_w, o_done, o_imm});
            else pass_cnt++;
            total_cnt++;
            if (op_q.size() == 0) begin
                $display("FAIL op_trace cycle %0d: unexpected op, scoreboard empty", c);
            end else begin
                e = op_q.pop_front();
                if (o_op !== e)
                    $display("FAIL op_trace cycle %0d: got r%0d,r%0d->r%0d fn=%b want r%0d,r%0d->r%0d fn=%b",
                             c, o_op.r1, o_op.r2, o_op.wa, o_op.fn, e.r1, e.r2, e.wa, e.fn);
                else pass_cnt++;
            end
            tick();
        end
        drive_start(keep);
        total_cnt++;
        if ({o_busy, o_hold, o_w, o_done} !== 4'b0001)
            $display("FAIL done_cycle %0d: busy/hold/w/done=%b want 0001", ops + 1, {o_busy, o_hold, o_w, o_done});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({o_busy, o_w, o_done} !== 3'b000)
            $display("FAIL after_done cycle %0d: busy/w/done=%b want 000", ops + 2, {o_busy, o_w, o_done});
        else pass_cnt++;
        while (res_q.size() > 0) begin
            er  = res_q.pop_front();
            got = sel3 ? rf3[er.addr] : rf2[er.addr];
            total_cnt++;
            if (got !== er.val) $display("FAIL result r%0d: got %0d want %0d", er.addr, got, er.val);
            else pass_cnt++;
        end
        total_cnt++;
        if (o_ovf !== exp_ovf) $display("FAIL ovf_end: got %b want %b", o_ovf, exp_ovf);
        else pass_cnt++;
    endtask

    int a2 [9] = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    int b2 [9] = '{5, 6, 7, 8, 0, 0, 0, 0, 0};

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if ({busy2, hold2, done2, w2, imm2, ovf2, ra1_2, ra2_2, wa_2, fn2,
                 busy3, hold3, done3, w3, imm3, ovf3, ra1_3, ra2_3, wa_3, fn3} !== 48'd0)
                $display("FAIL reset_idle cycle %0d: dut2 outs=%h dut3 outs=%h want 0", c,
                         {busy2, hold2, done2, w2, imm2, ovf2, ra1_2, ra2_2, wa_2, fn2},
                         {busy3, hold3, done3, w3, imm3, ovf3, ra1_3, ra2_3, wa_3, fn3});
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_mult2();
        sel3 = 1'b0;
        load_mats(2, 1, 5, a2, b2);
        push_expected(2, 1, 5, 9, 13);
        run(2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        sel3 = 1'b0;
        load_mats(2, 1, 5, a2, b2);
        push_expected(2, 1, 5, 9, 13);
        run(2, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        int seen_done;
        sel3 = 1'b0;
        load_mats(2, 1, 5, a2, b2);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if ({busy2, w2, done2, ra1_2, ra2_2, wa_2, fn2} !== 21'd0)
            $display("FAIL abort_state: busy/w/done/addr/fn=%h want 0", {busy2, w2, done2, ra1_2, ra2_2, wa_2, fn2});
        else pass_cnt++;
        reset = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (done2 || busy2) seen_done++;
            tick();
        end
        total_cnt++;
        if (seen_done != 0) $display("FAIL abort_quiet: %0d active/done cycles want 0", seen_done);
        else pass_cnt++;
        push_expected(2, 1, 5, 9, 13);
        run(2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        int ao [9] = '{100, 100, 0, 1, 0, 0, 0, 0, 0};
        int bo [9] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
        sel3 = 1'b0;
        load_mats(2, 1, 5, ao, bo);
        push_expected(2, 1, 5, 9, 13);
        run(2, 0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        total_cnt++;
        if (ovf2 !== 1'b1) $display("FAIL ovf_hold: got %b want 1", ovf2);
        else pass_cnt++;
        load_mats(2, 1, 5, a2, b2);
        push_expected(2, 1, 5, 9, 13);
        run(2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ndim3();
        int a3 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int id [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        sel3 = 1'b1;
        load_mats(3, 1, 10, a3, id);
        push_expected(3, 1, 10, 19, 28);
        run(3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel3 = 1'b1;
        push_expected(3, 1, 10, 19, 28);
        run(3, 0, 1'b0, 1'b1);
        push_expected(3, 1, 10, 19, 28);
        run(3, 0, 1'b0, 1'b1);
        start3 = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({busy3, done3} !== 2'b00) $display("FAIL b2b_stop: busy/done=%b want 00", {busy3, done3});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult2();
        test_start_ignored();
        test_reset_abort();
        test_overflow();
        test_ndim3();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mat_sched.md
Name: mat_sched

Overview:
- Multi-cycle sequencer that drives the picoMIPS register file and ALU to compute C = A x B for square matrices held in general-purpose registers.
- Sits beside the instruction decoder. While busy it owns the register read/write addresses, the ALU function, the immediate select and the write enable, and it holds the program counter.
- The CPU top muxes its decoder outputs with this block's outputs, selected by cpu_hold.

Parameters:
- n, 8: data width; used only to size the flags input.
- NDIM, 2: matrix dimension. Legal values are 2..3.
- A_BASE, 1: register number of A[0][0]. Storage is row-major: A[i][k] is at A_BASE + i*NDIM + k.
- B_BASE, 5: register number of B[0][0], row-major.
- C_BASE, 9: register number of C[0][0], row-major.
- T_REG, 13: scratch register for partial products.
- FUNC_ADD, 3'b001: ALU code for add. Bound to the alucodes.sv value at instantiation.
- FUNC_MUL, 3'b110: ALU code for multiply. Bound to the alucodes.sv value at instantiation.
- OVF_BIT, 1: index within flags of the ALU signed-overflow flag.

Ports:
- clk  in  1  system clock (the divided CPU clock).
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a multiply. Sampled only in IDLE.
- flags  in  4  ALU flags from the current operation.
- busy  out  1  high in every cycle that issues an op.
- cpu_hold  out  1  equal to busy. Freezes the PC and forces the decoder outputs off.
- done  out  1  one-cycle pulse after the last op.
- raddr1  out  5  register number for the ALU a operand.
- raddr2  out  5  register number for the ALU b operand.
- waddr  out  5  destination register number.
- alu_func  out  3  ALU function.
- imm  out  1  immediate select. Always 0.
- w  out  1  register write enable.
- ovf  out  1  sticky overflow seen during the current or last multiply.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge) forces:
  - state IDLE;
  - busy, cpu_hold, done, w, imm, ovf = 0;
  - raddr1, raddr2, waddr, alu_func = 0;
  - indices i, j, k = 0.
- Reset in the middle of an operation aborts immediately. The register-file contents are left as they are, and no done pulse is produced.
- States: IDLE, MUL0, MULT, ACC, FIN.
- IDLE:
  - Outputs are idle: w=0, addresses 0, alu_func 0.
  - If start==1: clear ovf, set i=j=k=0, go to MUL0.
- MUL0 issues raddr1=A[i][0], raddr2=B[0][j], waddr=C[i][j], alu_func=FUNC_MUL, w=1.
- MULT issues raddr1=A[i][k], raddr2=B[k][j], waddr=T_REG, alu_func=FUNC_MUL, w=1.
- ACC issues raddr1=C[i][j], raddr2=T_REG, waddr=C[i][j], alu_func=FUNC_ADD, w=1.
- Ordering and index stepping:
  - MUL0 is followed by MULT with k=1.
  - MULT is followed by ACC.
  - After ACC: if k<NDIM-1, increment k and go to MULT. Otherwise advance j; when j wraps, advance i; then go to MUL0 with k=0.
  - After the ACC for i=j=NDIM-1, go to FIN.
- Each op occupies exactly 1 cycle. The register file writes at the clock edge ending the op cycle, so the next op reads the updated value.
- Op count is NDIM*NDIM*(2*NDIM-1): 12 for NDIM=2, 45 for NDIM=3.
- busy=1 in MUL0, MULT and ACC only.
- Latency: with start sampled at edge 0, the first op is presented in cycle 1. The last op is in cycle ops. done=1 in cycle ops+1 (the FIN state) with busy=0. The block returns to IDLE in cycle ops+2.
- Start rules:
  - start while busy or in FIN is ignored; there is no queueing.
  - start held high continuously restarts from IDLE, giving one IDLE cycle between runs.
- ovf is set when w==1 and flags[OVF_BIT]==1 at a clock edge. It stays set until the next accepted start or reset.
- Address arithmetic is 5-bit and unsigned. The bases must place every matrix within r1..r31. Behaviour with overlapping bases is undefined.

Test Plan:
- Reset 0 for 2 cycles, then 1 -> all outputs 0, state IDLE, no writes for 5 idle cycles.
- NDIM=2, regs preloaded A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start at cycle 0:
  - cycle 1: MUL r1,r5->r9;
  - cycle 2: MUL r2,r7->r13;
  - cycle 3: ADD r9,r13->r9;
  - busy for cycles 1..12, done only in cycle 13;
  - final r9..r12 = 19, 22, 43, 50.
- start pulsed again at cycle 5 of a running multiply -> ignored. Same trace and same done cycle 13.
- reset driven low at cycle 6 of a run -> next cycle busy=0, w=0, no done pulse. A following start re-runs from MUL0 and gives correct results.
- A=[[100,0],[0,1]], B=[[1,0],[0,1]] with A[0][1]=100, B[1][0]=1 -> the ACC 100+100 sets the flags overflow and ovf=1. ovf holds after done and clears on the next accepted start.
- NDIM=3, identity B -> C equals A, 45 op cycles, done in cycle 46. start held high -> runs restart every 47 cycles.
